twiddle_sweep_gen: RTL and testbench



---
 rtl/twiddle_sweep_gen_if.sv | 14 +
 rtl/twiddle_sweep_gen.sv | 161 ++++++++++++++++
 tb/tb_twiddle_sweep_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/twiddle_sweep_gen_if.sv
// twiddle_sweep_gen_if: valid/ready coefficient stream from the twiddle generator to the butterfly unit.
interface twiddle_sweep_gen_if #(
    parameter int BITS      = 32,
    parameter int LOG2N_MAX = 6
);
    logic                 out_valid;
    logic                 out_ready;
    logic [BITS-1:0]      real_part;
    logic [BITS-1:0]      imag_part;
    logic [LOG2N_MAX-1:0] out_idx;
    logic                 out_last;
    modport master (output out_valid, real_part, imag_part, out_idx, out_last, input out_ready);
    modport slave  (input out_valid, real_part, imag_part, out_idx, out_last, output out_ready);
endinterface

// File: rtl/twiddle_sweep_gen.sv
// twiddle_sweep_gen: streams W^m = cos - j*sin for one radix-2 stage from a quarter-wave cosine ROM.
module twiddle_sweep_gen #(
    parameter int BITS      = 32,
    parameter int LOG2N_MAX = 6,
    parameter int LW        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [LW-1:0]          log2n_i,
    input  logic [LW-1:0]          stage_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    twiddle_sweep_gen_if.master    coef_o
);
    localparam int L = LOG2N_MAX;
    localparam int N = 1 << L;
    localparam int Q = N / 4;

    function automatic real cos_q(input int k);
        real x, t, c;
        x = 2.0 * 3.14159265358979323846 * $itor(k) / $itor(N);
        t = 1.0;
        c = 1.0;
        for (int n = 1; n < 20; n++) begin
            t = -t * x * x / $itor((2 * n - 1) * (2 * n));
            c = c + t;
        end
        return c;
    endfunction

    // Round a value in (0,1] to the nearest-even single-precision pattern.
    function automatic logic [31:0] to_single(input real x);
        real y, fr;
        int  e, f;
        e = 0;
        y = x;
        while (y < 1.0) begin
            y = y * 2.0;
            e = e - 1;
        end
        y  = y * 8388608.0;
        f  = $rtoi(y);
        fr = y - $itor(f);
        if (fr > 0.5 || (fr == 0.5 && f[0])) f = f + 1;
        if (f == 16777216) begin
            f = 8388608;
            e = e + 1;
        end
        return {1'b0, 8'(e + 127), f[22:0]};
    endfunction

    // Quarter-wave table built at elaboration; C[Q] is forced to an exact +0.0.
    function automatic logic [(Q+1)*BITS-1:0] build_rom();
        logic [(Q+1)*BITS-1:0] t;
        t = '0;
        for (int k = 0; k < Q; k++) t[k*BITS +: BITS] = to_single(cos_q(k));
        return t;
    endfunction

    function automatic logic [BITS-1:0] neg(input logic [BITS-1:0] x);
        return x == '0 ? '0 : {~x[BITS-1], x[BITS-2:0]};
    endfunction

    localparam logic [(Q+1)*BITS-1:0] ROM = build_rom();

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t          state_q;
    logic [LW-1:0]   s_q;
    logic [L-1:0]    j_q, p1_m_q, p1_j_q, idx_q;
    logic            p1_v_q, p1_last_q, v_q, last_q;
    logic [BITS-1:0] re_q, im_q;
    logic            busy_q, done_q, err_q;
    logic            en, legal, j_last;
    logic [L-1:0]    m_d;
    logic [1:0]      quad;
    logic [L-3:0]    r;
    logic [L-2:0]    qr;
    logic [BITS-1:0] c_r, c_qr, re_d, im_d;

    always_comb begin
        en     = !v_q || coef_o.out_ready;
        legal  = log2n_i >= LW'(3) && log2n_i <= LW'(L) && stage_i < log2n_i;
        j_last = 32'(j_q) == (32'd1 << s_q) - 32'd1;
        m_d    = j_q << (LW'(L - 1) - s_q);
        quad   = p1_m_q[L-1:L-2];
        r      = p1_m_q[L-3:0];
        qr     = (L-1)'(Q) - {1'b0, r};
        c_r    = ROM[int'(r) * BITS +: BITS];
        c_qr   = ROM[int'(qr) * BITS +: BITS];
        re_d   = quad == 2'd0 ? c_r : quad == 2'd1 ? neg(c_qr) : quad == 2'd2 ? neg(c_r) : c_qr;
        im_d   = quad == 2'd0 ? neg(c_qr) : quad == 2'd1 ? neg(c_r) : quad == 2'd2 ? c_qr : c_r;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_q       <= '0;
            j_q       <= '0;
            p1_v_q    <= 1'b0;
            p1_m_q    <= '0;
            p1_j_q    <= '0;
            p1_last_q <= 1'b0;
            v_q       <= 1'b0;
            re_q      <= '0;
            im_q      <= '0;
            idx_q     <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    if (legal) begin
                        s_q     <= stage_i;
                        j_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SWEEP;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                SWEEP: if (en) begin
                    j_q <= j_q + 1'b1;
                    if (j_last) state_q <= DRAIN;
                end
                DRAIN: if (v_q && coef_o.out_ready && last_q) begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (en) begin
                p1_v_q    <= state_q == SWEEP;
                p1_m_q    <= m_d;
                p1_j_q    <= j_q;
                p1_last_q <= j_last;
                v_q       <= p1_v_q;
                re_q      <= p1_v_q ? re_d : '0;
                im_q      <= p1_v_q ? im_d : '0;
                idx_q     <= p1_v_q ? p1_j_q : '0;
                last_q    <= p1_v_q && p1_last_q;
            end
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign err_o            = err_q;
    assign coef_o.out_valid = v_q;
    assign coef_o.real_part = re_q;
    assign coef_o.imag_part = im_q;
    assign coef_o.out_idx   = idx_q;
    assign coef_o.out_last  = last_q;
endmodule

// File: tb/tb_twiddle_sweep_gen.sv
// tb_twiddle_sweep_gen: directed and randomized sweeps on 16-point and 64-point generators against a cos/sin model.
module tb_twiddle_sweep_gen;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0, rst_n = 1'b0, start4 = 1'b0, start6 = 1'b0, rdy = 1'b1, sel = 1'b0;
    logic [3:0] log2n = '0, stage = '0;
    logic busy4, done4, err4, busy6, done6, err6;
    logic v, last, busy, done, err;
    logic [31:0] re, im;
    logic [5:0] idx;
    logic [63:0] got[$];
    int vectors = 0, miscompares = 0;

    twiddle_sweep_gen_if #(.BITS(32), .LOG2N_MAX(4)) i4();
    twiddle_sweep_gen_if #(.BITS(32), .LOG2N_MAX(6)) i6();
    assign i4.out_ready = rdy;
    assign i6.out_ready = rdy;

    twiddle_sweep_gen #(.BITS(32), .LOG2N_MAX(4), .LW(4)) d4 (
        .clk(clk), .rst_n(rst_n), .start_i(start4), .log2n_i(log2n), .stage_i(stage),
        .busy_o(busy4), .done_o(done4), .err_o(err4), .coef_o(i4.master));
    twiddle_sweep_gen #(.BITS(32), .LOG2N_MAX(6), .LW(4)) d6 (
        .clk(clk), .rst_n(rst_n), .start_i(start6), .log2n_i(log2n), .stage_i(stage),
        .busy_o(busy6), .done_o(done6), .err_o(err6), .coef_o(i6.master));

    always #5 clk = ~clk;

    always_comb begin
        v    = sel ? i6.out_valid : i4.out_valid;
        re   = sel ? i6.real_part : i4.real_part;
        im   = sel ? i6.imag_part : i4.imag_part;
        idx  = sel ? i6.out_idx : {2'b00, i4.out_idx};
        last = sel ? i6.out_last : i4.out_last;
        busy = sel ? busy6 : busy4;
        done = sel ? done6 : done4;
        err  = sel ? err6 : err4;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Double -> single with round-to-nearest-even; near-zero results are exact +0.0.
    function automatic logic [31:0] enc(input real x);
        logic [63:0] b;
        logic [31:0] s;
        if (x < 1e-9 && x > -1e-9) return 32'h0;
        b = $realtobits(x);
        s = {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
        if (b[28] && ((|b[27:0]) || b[29])) s = s + 32'd1;
        return s;
    endfunction

    // Stage st uses the 2^(st+1)-point roots of unity: W = exp(-j*2*pi*j/2^(st+1)).
    function automatic logic [63:0] tw(input int st, input int j);
        real a;
        a = 2.0 * PI * $itor(j) / $itor(1 << (st + 1));
        return {enc($cos(a)), enc(-$sin(a))};
    endfunction

    task automatic pulse_start(input bit s);
        if (s) start6 = 1'b1; else start4 = 1'b1;
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic run_sweep(input bit s, input int lg, input int st, input int mode, input bit poke, input int abort_at);
        int n, cyc, words;
        logic [71:0] held;
        bit holding;
        logic [63:0] e;
        words = 1 << st;
        sel = s; log2n = 4'(lg); stage = 4'(st); rdy = 1'b1;
        got.delete();
        pulse_start(s);
        step();
        start4 = 1'b0; start6 = 1'b0;
        chk("busy_rise", 72'(busy), 72'd1);
        chk("latency_c1_valid", 72'(v), 72'd0);
        if (poke) begin
            pulse_start(s);
            log2n = 4'd15;
        end
        step();
        start4 = 1'b0; start6 = 1'b0;
        chk("latency_c2_valid", 72'(v), 72'd0);
        if (poke) chk("busy_start_err", 72'(err), 72'd0);
        step();
        chk("first_valid", 72'(v), 72'd1);
        n = 0; cyc = 0; holding = 1'b0; held = '0;
        while (n < words && cyc < 400) begin
            if (abort_at == n && v) begin
                rst_n = 1'b0;
                #1;
                chk("abort_outputs_zero", {v, re, im, idx, last, busy, done, err}, 72'd0);
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk("abort_no_done", {v, busy, done}, 72'd0);
                end
                rst_n = 1'b1;
                step();
                return;
            end
            if (holding) chk("stall_hold", {1'b0, idx, last, re, im}, held);
            rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
            if (v && rdy) begin
                e = tw(st, n);
                chk("real_part", 72'(re), 72'(e[63:32]));
                chk("imag_part", 72'(im), 72'(e[31:0]));
                chk("out_idx", 72'(idx), 72'(n));
                chk("out_last", 72'(last), 72'(n == words - 1));
                got.push_back({re, im});
                n++;
                holding = 1'b0;
            end else begin
                holding = v;
                held = {1'b0, idx, last, re, im};
            end
            if (poke) chk("busy_start_err", 72'(err), 72'd0);
            cyc++;
            step();
        end
        rdy = 1'b1;
        chk("word_count", 72'(n), 72'(words));
        chk("done_pulse", 72'(done), 72'd1);
        chk("busy_fall", 72'(busy), 72'd0);
        chk("no_extra_word", 72'(v), 72'd0);
        step();
        chk("done_single", 72'(done), 72'd0);
    endtask

    task automatic illegal(input bit s, input int lg, input int st);
        sel = s; log2n = 4'(lg); stage = 4'(st);
        pulse_start(s);
        step();
        start4 = 1'b0; start6 = 1'b0;
        chk("err_pulse", {v, busy, err}, 72'd1);
        step();
        chk("err_single", {v, busy, err}, 72'd0);
        step();
        chk("illegal_idle", {v, busy, done}, 72'd0);
    endtask

    logic [63:0] tp[4];
    int st, lmax, lg;
    bit rs;

    initial begin
        tp[0] = {32'h3F800000, 32'h00000000};
        tp[1] = {32'h3F3504F3, 32'hBF3504F3};
        tp[2] = {32'h00000000, 32'hBF800000};
        tp[3] = {32'hBF3504F3, 32'hBF3504F3};
        step();
        step();
        sel = 1'b0; #1;
        chk("reset_outputs_n16", {v, re, im, idx, last, busy, done, err}, 72'd0);
        sel = 1'b1; #1;
        chk("reset_outputs_n64", {v, re, im, idx, last, busy, done, err}, 72'd0);
        rst_n = 1'b1;
        step();

        run_sweep(1'b0, 4, 2, 0, 1'b0, -1);
        for (int k = 0; k < 4; k++) chk($sformatf("plan_s2_j%0d", k), 72'(got[k]), 72'(tp[k]));
        run_sweep(1'b0, 4, 2, 1, 1'b0, -1);
        for (int k = 0; k < 4; k++) chk($sformatf("plan_s2_stall_j%0d", k), 72'(got[k]), 72'(tp[k]));

        run_sweep(1'b0, 4, 3, 0, 1'b0, -1);
        chk("plan_s3_j6", 72'(got[6]), {8'd0, 32'hBF3504F3, 32'hBF3504F3});

        illegal(1'b0, 5, 0);
        illegal(1'b0, 4, 4);
        illegal(1'b1, 2, 0);
        run_sweep(1'b0, 4, 1, 0, 1'b1, -1);

        run_sweep(1'b0, 4, 3, 0, 1'b0, 2);
        run_sweep(1'b0, 4, 3, 0, 1'b0, -1);
        run_sweep(1'b0, 4, 0, 1, 1'b0, -1);

        run_sweep(1'b1, 6, 5, 0, 1'b0, -1);
        chk("n64_j0_imag_pos_zero", 72'(got[0][31:0]), 72'd0);
        chk("n64_j16_real_pos_zero", 72'(got[16][63:32]), 72'd0);
        run_sweep(1'b1, 6, 5, 2, 1'b0, -1);

        for (int t = 0; t < 8; t++) begin
            rs   = 1'($urandom_range(0, 1));
            lmax = rs ? 6 : 4;
            st   = $urandom_range(0, lmax - 1);
            lg   = $urandom_range(st + 1 < 3 ? 3 : st + 1, lmax);
            run_sweep(rs, lg, st, 2, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
